// File: rtl/reset_request_generator_pkg.sv
// Shared state encoding and reset-cause codes for the reset request generator.
package reset_request_generator_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        ASSERT   = 2'd2,
        HOLDOFF  = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_POR    = 2'b01;
    localparam logic [1:0] CAUSE_BUTTON = 2'b10;
    localparam logic [1:0] CAUSE_SOFT   = 2'b11;

endpackage

// File: rtl/reset_request_generator_if.sv
// Request inputs and reset/status outputs of the reset request generator.
interface reset_request_generator_if;
    logic       button_n;
    logic       soft_req;
    logic       reset_req_n;
    logic       busy;
    logic [1:0] cause;

    modport master (
        output button_n,
        output soft_req,
        input  reset_req_n,
        input  busy,
        input  cause
    );

    modport slave (
        input  button_n,
        input  soft_req,
        output reset_req_n,
        output busy,
        output cause
    );
endinterface

// File: rtl/reset_request_generator_input_synchronizer.sv
// Purpose: 2-FF single-bit synchronizer with a parameterized reset value.
// Latency: input visible at q after two clk edges.
// Backpressure: none; free-running sampler.
module input_synchronizer #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/reset_request_generator.sv
// Purpose: merges power-on, debounced button and software sources into a minimum-width active-low reset request.
// Latency: soft_req -> reset_req_n low one edge later; button accepted after a full debounce window.
// Backpressure: requests arriving in ASSERT/HOLDOFF are dropped, never queued.
module reset_request_generator
    import reset_request_generator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 8,
    parameter int HOLDOFF_CYCLES  = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                        clk_sync,
    input  logic                        reset_async,
    reset_request_generator_if.slave    rr
);
    localparam int MAX_CYC = (DEBOUNCE_CYCLES > PULSE_CYCLES)
                           ? ((DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ? DEBOUNCE_CYCLES : HOLDOFF_CYCLES)
                           : ((PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES);

    generate
        if (DEBOUNCE_CYCLES < 1 || PULSE_CYCLES < 1 || HOLDOFF_CYCLES < 1) begin : g_bad_cycles
            $error("reset_request_generator: all cycle parameters must be >= 1");
        end
        if (CNT_WIDTH < 1 || CNT_WIDTH > 31 || ((MAX_CYC - 1) >> CNT_WIDTH) != 0) begin : g_bad_width
            $error("reset_request_generator: CNT_WIDTH too small for the largest cycle count");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] DEB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] PULSE_LAST = CNT_WIDTH'(PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(HOLDOFF_CYCLES - 1);

    logic btn_sync;

    input_synchronizer #(.RST_VAL(1'b1)) u_btn_sync (
        .clk (clk_sync),
        .rst (reset_async),
        .d   (rr.button_n),
        .q   (btn_sync)
    );

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [1:0]             cause_q, cause_d;
    logic                   req_n_q, req_n_d;

    always_ff @(posedge clk_sync or posedge reset_async) begin
        if (reset_async) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            cause_q <= CAUSE_POR;
            req_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            req_n_q <= req_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (rr.soft_req) begin
                    state_d = ASSERT;
                    cause_d = CAUSE_SOFT;
                end else if (!btn_sync) begin
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (rr.soft_req) begin
                    state_d = ASSERT;
                    cause_d = CAUSE_SOFT;
                end else if (btn_sync) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ASSERT;
                    cause_d = CAUSE_BUTTON;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ASSERT: begin
                // Counter parks at PULSE_LAST while a held button stretches the pulse.
                if (cnt_q != PULSE_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!(cause_q == CAUSE_BUTTON && !btn_sync)) begin
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
        req_n_d = (state_d != ASSERT);
    end

    assign rr.reset_req_n = req_n_q;
    assign rr.busy        = (state_q != IDLE);
    assign rr.cause       = cause_q;
endmodule

// File: tb/tb_reset_request_generator.sv
// Scoreboarded bench: stimulus queues expected pulses and busy-fall cycles; a negedge monitor checks them.
module tb_reset_request_generator;
    import reset_request_generator_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int         start_c;
        int         end_c;
        logic [1:0] cause;
    } pulse_t;

    pulse_t exp_q[$];
    int     busy_q[$];

    reset_request_generator_if rr_if();

    reset_request_generator #(
        .DEBOUNCE_CYCLES (16),
        .PULSE_CYCLES    (8),
        .HOLDOFF_CYCLES  (4),
        .CNT_WIDTH       (16)
    ) dut (
        .clk_sync    (clk),
        .reset_async (rst),
        .rr          (rr_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pulse(input int s, input int e, input logic [1:0] c, input int bf);
        pulse_t p;
        p.start_c = s;
        p.end_c   = e;
        p.cause   = c;
        exp_q.push_back(p);
        busy_q.push_back(bf);
    endtask

    // Monitor: a pulse is complete when reset_req_n returns high
    logic prev_req  = 1'b1;
    logic prev_busy = 1'b0;
    int   start_c   = 0;

    always @(negedge clk) begin
        pulse_t e;
        if (prev_req && !rr_if.reset_req_n) start_c = cyc;
        if (!prev_req && rr_if.reset_req_n) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: pulse %0d..%0d, none expected", start_c, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_start", start_c, e.start_c);
                check("pulse_end", cyc, e.end_c);
                check("pulse_cause", int'(rr_if.cause), int'(e.cause));
            end
        end
        if (prev_busy && !rr_if.busy) begin
            if (busy_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_busy_fall: at cycle %0d, none expected", cyc);
            end else begin
                check("busy_fall", cyc, busy_q.pop_front());
            end
        end
        prev_req  = rr_if.reset_req_n;
        prev_busy = rr_if.busy;
    end

    initial begin
        rr_if.button_n = 1'b1;
        rr_if.soft_req = 1'b0;
        rst = 1'b1;

        // Power-on: released after edge 3, 8 more low cycles, holdoff of 4
        expect_pulse(1, 11, CAUSE_POR, 15);
        @(negedge clk);
        check("rst_req_n", int'(rr_if.reset_req_n), 0);
        check("rst_busy", int'(rr_if.busy), 1);
        check("rst_cause", int'(rr_if.cause), int'(CAUSE_POR));
        at_cyc(3);
        rst = 1'b0;

        // Software pulse sampled at edge 100
        expect_pulse(100, 108, CAUSE_SOFT, 112);
        at_cyc(99);  rr_if.soft_req = 1'b1;
        at_cyc(100); rr_if.soft_req = 1'b0;

        // Bounce: 10 low cycles rejected, cause keeps its software value
        busy_q.push_back(163);
        at_cyc(150); rr_if.button_n = 1'b0;
        at_cyc(160); rr_if.button_n = 1'b1;
        at_cyc(180);
        check("bounce_cause", int'(rr_if.cause), int'(CAUSE_SOFT));
        check("bounce_req_n", int'(rr_if.reset_req_n), 1);

        // Held button: asserted 19 after the pin edge, stretched until 3 after release
        expect_pulse(219, 263, CAUSE_BUTTON, 267);
        at_cyc(200); rr_if.button_n = 1'b0;
        at_cyc(260); rr_if.button_n = 1'b1;

        // Software wins over button in the same cycle; second request in holdoff dropped
        expect_pulse(303, 311, CAUSE_SOFT, 315);
        at_cyc(300); rr_if.button_n = 1'b0;
        at_cyc(302); rr_if.soft_req = 1'b1;
        at_cyc(303); rr_if.soft_req = 1'b0;
        at_cyc(304); rr_if.button_n = 1'b1;
        at_cyc(312); rr_if.soft_req = 1'b1;
        at_cyc(313); rr_if.soft_req = 1'b0;

        // Async reset in the 4th ASSERT cycle of a button reset restarts a full POR pulse
        expect_pulse(419, 431, CAUSE_POR, 435);
        at_cyc(400); rr_if.button_n = 1'b0;
        at_cyc(422); rst = 1'b1; rr_if.button_n = 1'b1;
        at_cyc(423); rst = 1'b0;

        // Debounce boundary: pin low 16 cycles is one short and rejected
        busy_q.push_back(519);
        at_cyc(500); rr_if.button_n = 1'b0;
        at_cyc(516); rr_if.button_n = 1'b1;

        // Pin low 17 cycles is just accepted and gives a minimum-width pulse
        expect_pulse(619, 627, CAUSE_BUTTON, 631);
        at_cyc(600); rr_if.button_n = 1'b0;
        at_cyc(617); rr_if.button_n = 1'b1;

        at_cyc(700);
        check("pulses_outstanding", exp_q.size(), 0);
        check("busy_falls_outstanding", busy_q.size(), 0);
        check("final_req_n", int'(rr_if.reset_req_n), 1);
        check("final_busy", int'(rr_if.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
